// File: rtl/updown_sweep_controller.sv
// updown_sweep_controller: owns a BITS-wide up/down count register and sweeps it
// bottom -> top -> bottom for a programmed number of sweeps. It dwells at each end
// point and reports busy, done and configuration-error status.
module updown_sweep_controller #(
    parameter int unsigned BITS    = 4,
    parameter int unsigned DWELL_W = 4,
    parameter int unsigned SWP_W   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [BITS-1:0]    bottom,
    input  logic [BITS-1:0]    top,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [SWP_W-1:0]   sweeps,
    output logic [BITS-1:0]    Q,
    output logic               up,
    output logic               enable,
    output logic               busy,
    output logic               done,
    output logic               err
);

    // Binary state encoding; code 3'd7 is unused and recovers to idle.
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StRise    = 3'd1;
    localparam logic [2:0] StHoldTop = 3'd2;
    localparam logic [2:0] StFall    = 3'd3;
    localparam logic [2:0] StHoldBot = 3'd4;
    localparam logic [2:0] StDone    = 3'd5;
    localparam logic [2:0] StErr     = 3'd6;

    localparam logic [BITS-1:0]    QOne     = BITS'(1);
    localparam logic [DWELL_W-1:0] DwellOne = DWELL_W'(1);
    localparam logic [SWP_W-1:0]   SwpOne   = SWP_W'(1);

    logic [2:0]         state_q, state_d;
    logic [BITS-1:0]    q_q, q_d;
    logic [BITS-1:0]    bot_q, bot_d;
    logic [BITS-1:0]    top_q, top_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] dcnt_q, dcnt_d;
    logic [SWP_W-1:0]   rem_q, rem_d;

    logic [BITS-1:0] q_inc;
    logic [BITS-1:0] q_dec;
    logic            cfg_ok;
    logic            in_run;

    // Step values and start qualification.
    always_comb begin
        q_inc  = q_q + QOne;
        q_dec  = q_q - QOne;
        // bottom < top guarantees the count never wraps during a sweep.
        cfg_ok = (bottom < top) && (sweeps != '0);
        in_run = (state_q == StRise) || (state_q == StHoldTop) ||
                 (state_q == StFall) || (state_q == StHoldBot);
    end

    // Next-state, count and counter update.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        bot_d   = bot_q;
        top_d   = top_q;
        dwell_d = dwell_q;
        dcnt_d  = dcnt_q;
        rem_d   = rem_q;

        case (state_q)
            StIdle: begin
                // abort in idle suppresses a simultaneous start.
                if (start && !abort) begin
                    if (cfg_ok) begin
                        bot_d   = bottom;
                        top_d   = top;
                        dwell_d = dwell;
                        rem_d   = sweeps;
                        q_d     = bottom;
                        state_d = StRise;
                    end else begin
                        state_d = StErr;
                    end
                end
            end

            StRise: begin
                q_d = q_inc;
                if (q_inc == top_q) begin
                    dcnt_d  = dwell_q;
                    state_d = StHoldTop;
                end
            end

            StHoldTop: begin
                if (dcnt_q == '0) begin
                    state_d = StFall;
                end else begin
                    dcnt_d = dcnt_q - DwellOne;
                end
            end

            StFall: begin
                q_d = q_dec;
                if (q_dec == bot_q) begin
                    if (rem_q == SwpOne) begin
                        state_d = StDone;
                    end else begin
                        rem_d   = rem_q - SwpOne;
                        dcnt_d  = dwell_q;
                        state_d = StHoldBot;
                    end
                end
            end

            StHoldBot: begin
                if (dcnt_q == '0) begin
                    state_d = StRise;
                end else begin
                    dcnt_d = dcnt_q - DwellOne;
                end
            end

            StDone: state_d = StIdle;

            StErr: state_d = StIdle;

            default: state_d = StIdle;
        endcase

        // Abort freezes the count where it is and drops straight to idle.
        if (abort && in_run) begin
            state_d = StIdle;
            q_d     = q_q;
            dcnt_d  = dcnt_q;
            rem_d   = rem_q;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            q_q     <= '0;
            bot_q   <= '0;
            top_q   <= '0;
            dwell_q <= '0;
            dcnt_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            bot_q   <= bot_d;
            top_q   <= top_d;
            dwell_q <= dwell_d;
            dcnt_q  <= dcnt_d;
            rem_q   <= rem_d;
        end
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        Q      = q_q;
        up     = (state_q == StRise);
        enable = (state_q == StRise) || (state_q == StFall);
        busy   = in_run;
        done   = (state_q == StDone);
        err    = (state_q == StErr);
    end

endmodule
